// File: rtl/period_meas_ctrl.sv
// Purpose: sequences the period/duty measurement block (arm, collect, average) and hands one result to the readout.
// Latency: OUT_VALID rises 2 cycles after the final accepted PERIOD_FLAG; a timeout is reported after TIMEOUT_CYC-1 idle WAIT cycles.
// Backpressure: the result is held in OUT until OUT_READY; meanwhile the measurement block is held in reset and flags are dropped.
module period_meas_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 25000000,
    parameter bit          SKIP_FIRST  = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        START,
    input  logic        CONT,
    input  logic [1:0]  AVG_LOG2,
    input  logic [24:0] PERIOD1,
    input  logic [24:0] PERIOD2,
    input  logic        PERIOD_FLAG,
    output logic        MEAS_RSTB,
    output logic        BUSY,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [24:0] HIGH_AVG,
    output logic [24:0] PER_AVG,
    output logic        TIMEOUT_ERR
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_WAIT = 3'd2,
        S_DIV  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    logic          arm_cnt_q, arm_cnt_d;
    logic [1:0]    n_log2_q, n_log2_d;
    logic [27:0]   acc1_q, acc1_d;
    logic [27:0]   acc2_q, acc2_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          skip_q, skip_d;
    logic [24:0]   high_q, high_d;
    logic [24:0]   per_q, per_d;
    logic          tmo_q, tmo_d;

    // A flag is a usable sample only after the skip is spent and the period is sane.
    logic          sample_ok;
    logic [3:0]    cnt_inc;
    logic [TW-1:0] tcnt_inc;
    logic          acc_done;
    logic          tmo_hit;

    assign sample_ok = PERIOD_FLAG && !skip_q && (PERIOD2 != 25'd0) && (PERIOD1 <= PERIOD2);
    assign cnt_inc   = cnt_q + 4'd1;
    assign tcnt_inc  = tcnt_q + TW'(1);
    assign acc_done  = sample_ok && (cnt_inc == (4'd1 << n_log2_q));
    assign tmo_hit   = !PERIOD_FLAG && (tcnt_inc == TLIM);

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state_q   <= S_IDLE;
            arm_cnt_q <= 1'b0;
            n_log2_q  <= 2'd0;
            acc1_q    <= '0;
            acc2_q    <= '0;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            skip_q    <= 1'b0;
            high_q    <= '0;
            per_q     <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            n_log2_q  <= n_log2_d;
            acc1_q    <= acc1_d;
            acc2_q    <= acc2_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            skip_q    <= skip_d;
            high_q    <= high_d;
            per_q     <= per_d;
            tmo_q     <= tmo_d;
        end
    end

    // Next-state logic; an accepted final flag beats the timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (START || CONT) state_d = S_ARM;
            S_ARM:  if (arm_cnt_q)     state_d = S_WAIT;
            S_WAIT: begin
                if (acc_done)     state_d = S_DIV;
                else if (tmo_hit) state_d = S_OUT;
            end
            S_DIV:  state_d = S_OUT;
            S_OUT:  if (OUT_READY)     state_d = CONT ? S_ARM : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: arm clears, WAIT accumulates or counts towards timeout, DIV averages.
    always_comb begin
        arm_cnt_d = 1'b0;
        n_log2_d  = n_log2_q;
        acc1_d    = acc1_q;
        acc2_d    = acc2_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        skip_d    = skip_q;
        high_d    = high_q;
        per_d     = per_q;
        tmo_d     = tmo_q;
        case (state_q)
            S_ARM: begin
                arm_cnt_d = ~arm_cnt_q;
                if (!arm_cnt_q) n_log2_d = AVG_LOG2;
                acc1_d = '0;
                acc2_d = '0;
                cnt_d  = '0;
                tcnt_d = '0;
                skip_d = SKIP_FIRST;
            end
            S_WAIT: begin
                if (PERIOD_FLAG) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                        tcnt_d = '0;
                    end else if (sample_ok) begin
                        acc1_d = acc1_q + 28'(PERIOD1);
                        acc2_d = acc2_q + 28'(PERIOD2);
                        cnt_d  = cnt_inc;
                        tcnt_d = '0;
                    end
                end else begin
                    tcnt_d = tcnt_inc;
                    if (tmo_hit) begin
                        high_d = '0;
                        per_d  = '0;
                        tmo_d  = 1'b1;
                    end
                end
            end
            S_DIV: begin
                high_d = 25'(acc1_q >> n_log2_q);
                per_d  = 25'(acc2_q >> n_log2_q);
                tmo_d  = 1'b0;
            end
            default: ;
        endcase
    end

    // Outputs decoded from state; the measurement block runs only in WAIT.
    always_comb begin
        MEAS_RSTB   = (state_q == S_WAIT);
        BUSY        = (state_q != S_IDLE);
        OUT_VALID   = (state_q == S_OUT);
        HIGH_AVG    = high_q;
        PER_AVG     = per_q;
        TIMEOUT_ERR = tmo_q;
    end

endmodule

// File: tb/tb_period_meas_ctrl.sv
// Scoreboarded bench for period_meas_ctrl: directed runs push expected results, a monitor checks each presented result.
module tb_period_meas_ctrl;

    logic        CLK = 1'b0;
    logic        RSTB = 1'b0;
    logic        START = 1'b0;
    logic        CONT = 1'b0;
    logic [1:0]  AVG_LOG2 = 2'd0;
    logic [24:0] PERIOD1 = '0;
    logic [24:0] PERIOD2 = '0;
    logic        PERIOD_FLAG = 1'b0;
    logic        MEAS_RSTB, BUSY, OUT_VALID, TIMEOUT_ERR;
    logic        OUT_READY = 1'b1;
    logic [24:0] HIGH_AVG, PER_AVG;

    period_meas_ctrl #(.TIMEOUT_CYC(100), .SKIP_FIRST(1'b1)) dut (
        .CLK(CLK), .RSTB(RSTB), .START(START), .CONT(CONT), .AVG_LOG2(AVG_LOG2),
        .PERIOD1(PERIOD1), .PERIOD2(PERIOD2), .PERIOD_FLAG(PERIOD_FLAG),
        .MEAS_RSTB(MEAS_RSTB), .BUSY(BUSY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .HIGH_AVG(HIGH_AVG), .PER_AVG(PER_AVG), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [24:0] h;
        logic [24:0] p;
        logic        t;
        int          c;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    logic ov_prev = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle a result is presented it must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (OUT_VALID && !ov_prev) rise_cyc = cyc;
        ov_prev = OUT_VALID;
        if (OUT_VALID) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'(OUT_VALID), 32'd0);
            end else begin
                chk("high_avg", 32'(HIGH_AVG), 32'(q[0].h));
                chk("per_avg", 32'(PER_AVG), 32'(q[0].p));
                chk("timeout_err", 32'(TIMEOUT_ERR), 32'(q[0].t));
                if (OUT_READY) begin
                    if (q[0].c >= 0) chk("out_latency", 32'(rise_cyc), 32'(q[0].c));
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // Drives one flag cycle; when expect_out is set, the result is due 2 cycles later.
    task automatic flag(input int p1, input int p2, input bit expect_out,
                        input int eh, input int ep);
        exp_t e;
        PERIOD1 = 25'(p1);
        PERIOD2 = 25'(p2);
        PERIOD_FLAG = 1'b1;
        if (expect_out) begin
            e.h = 25'(eh); e.p = 25'(ep); e.t = 1'b0; e.c = cyc + 2;
            q.push_back(e);
        end
        tick();
        PERIOD_FLAG = 1'b0;
        tick();
    endtask

    task automatic wait_wait(output int w);
        for (int i = 0; i < 20 && !MEAS_RSTB; i++) tick();
        chk("reach_wait", 32'(MEAS_RSTB), 32'd1);
        w = cyc;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && q.size() != 0; i++) tick();
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic push_tmo(input int c);
        exp_t e;
        e.h = '0; e.p = '0; e.t = 1'b1; e.c = c;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int w;
        int bad;
        // Reset state.
        repeat (3) tick();
        chk("rst_meas_rstb", 32'(MEAS_RSTB), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_high", 32'(HIGH_AVG), 32'd0);
        chk("rst_per", 32'(PER_AVG), 32'd0);
        chk("rst_tmo", 32'(TIMEOUT_ERR), 32'd0);
        RSTB = 1'b1;
        tick();

        // Single shot, N=1: ARM is exactly two cycles, first flag skipped.
        pulse_start();
        chk("arm1_meas_rstb", 32'(MEAS_RSTB), 32'd0);
        chk("arm1_busy", 32'(BUSY), 32'd1);
        tick();
        chk("arm2_meas_rstb", 32'(MEAS_RSTB), 32'd0);
        tick();
        chk("wait_meas_rstb", 32'(MEAS_RSTB), 32'd1);
        flag(10, 30, 0, 0, 0);
        flag(12, 40, 1, 12, 40);
        wait_drain();
        tick();
        chk("single_idle", 32'(BUSY), 32'd0);

        // Averaging N=4; AVG_LOG2 changed mid-run must not matter.
        AVG_LOG2 = 2'd2;
        pulse_start();
        wait_wait(w);
        AVG_LOG2 = 2'd0;
        flag(5, 5, 0, 0, 0);
        flag(100, 200, 0, 0, 0);
        flag(101, 200, 0, 0, 0);
        pulse_start();
        flag(102, 201, 0, 0, 0);
        flag(103, 202, 1, 101, 200);
        wait_drain();
        tick();

        // Rejection: zero period and high > period are not counted.
        pulse_start();
        wait_wait(w);
        flag(7, 9, 0, 0, 0);
        flag(7, 0, 0, 0, 0);
        flag(50, 40, 0, 0, 0);
        flag(20, 40, 1, 20, 40);
        wait_drain();
        tick();

        // Timeout with CONT: re-arms, then CONT dropped mid-run returns to IDLE.
        CONT = 1'b1;
        wait_wait(w);
        push_tmo(w + 99);
        wait_drain();
        chk("rearm_busy", 32'(BUSY), 32'd1);
        chk("rearm_meas_rstb", 32'(MEAS_RSTB), 32'd0);
        chk("rearm_valid", 32'(OUT_VALID), 32'd0);
        wait_wait(w);
        push_tmo(w + 99);
        CONT = 1'b0;
        wait_drain();
        tick();
        chk("cont_drop_idle", 32'(BUSY), 32'd0);

        // Backpressure in continuous mode: result held, block kept in reset.
        CONT = 1'b1;
        OUT_READY = 1'b0;
        wait_wait(w);
        flag(1, 2, 0, 0, 0);
        flag(30, 60, 1, 30, 60);
        for (int i = 0; i < 10 && !OUT_VALID; i++) tick();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            PERIOD_FLAG = i[0];
            PERIOD1 = 25'(i);
            PERIOD2 = 25'(i + 5);
            START = (i == 20);
            if (!OUT_VALID || MEAS_RSTB) bad++;
            tick();
        end
        PERIOD_FLAG = 1'b0;
        START = 1'b0;
        chk("hold_valid_reset", 32'(bad), 32'd0);
        OUT_READY = 1'b1;
        wait_drain();
        chk("bp_rearm_busy", 32'(BUSY), 32'd1);
        CONT = 1'b0;
        wait_wait(w);
        flag(3, 3, 0, 0, 0);
        flag(8, 16, 1, 8, 16);
        wait_drain();
        tick();
        chk("bp_idle", 32'(BUSY), 32'd0);

        // Reset from mid-WAIT clears everything, including held averages.
        pulse_start();
        wait_wait(w);
        RSTB = 1'b0;
        repeat (3) tick();
        chk("mid_rst_meas_rstb", 32'(MEAS_RSTB), 32'd0);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        chk("mid_rst_high", 32'(HIGH_AVG), 32'd0);
        chk("mid_rst_per", 32'(PER_AVG), 32'd0);
        RSTB = 1'b1;
        tick();
        pulse_start();
        chk("post_rst_arm1", 32'(MEAS_RSTB), 32'd0);
        tick();
        chk("post_rst_arm2", 32'(MEAS_RSTB), 32'd0);
        tick();
        chk("post_rst_wait", 32'(MEAS_RSTB), 32'd1);
        flag(4, 4, 0, 0, 0);
        flag(3, 9, 1, 3, 9);
        wait_drain();
        repeat (5) tick();
        chk("final_queue", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
